// File: rtl/uart_alu_core.sv
// Packet byte-stream ALU between uart_rx and uart_tx: echoes payloads or reduces
// OPW-bit little-endian operands with add, subtract or shift-add multiply.
module uart_alu_core #(
  parameter int unsigned OPW      = 32,
  parameter int unsigned LEN_W    = 16,
  parameter logic [7:0]  OP_ECHO  = 8'hEC,
  parameter logic [7:0]  OP_ADD   = 8'hA0,
  parameter logic [7:0]  OP_SUB   = 8'hA1,
  parameter logic [7:0]  OP_MUL   = 8'hA2,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned NB = OPW / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned MW = $clog2(OPW);

  typedef enum logic [2:0] {
    StHdr,
    StEcho,
    StOpnd,
    StMulRun,
    StDrain,
    StTxRes,
    StTxErr
  } state_e;

  state_e           state_q;
  logic [1:0]       hdr_cnt_q;
  logic [7:0]       op_q;
  logic [7:0]       len_lo_q;
  logic [LEN_W-1:0] rem_q;
  logic [BW-1:0]    byte_cnt_q;
  logic [BW-1:0]    tx_cnt_q;
  logic [MW-1:0]    mul_cnt_q;
  logic             first_q;
  logic [OPW-1:0]   acc_q;
  logic [OPW-1:0]   opnd_q;
  logic [OPW-1:0]   mcand_q;
  logic             err_q;

  logic             in_fire;
  logic             out_fire;
  logic             op_done;
  logic             pay_last;
  logic             is_arith;
  logic             pay_bad;
  logic [OPW-1:0]   opnd_full;
  logic [LEN_W-1:0] len_w;
  logic [LEN_W-1:0] pay;

  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  always_comb begin
    // Operand bytes arrive LSB first, so each new byte enters at the top.
    opnd_full = OPW'({data_i, opnd_q} >> 8);
    len_w     = LEN_W'({data_i, len_lo_q});
    pay       = len_w - LEN_W'(4);
    is_arith  = op_q inside {OP_ADD, OP_SUB, OP_MUL};
    pay_bad   = (pay == '0) || ((pay % LEN_W'(NB)) != '0);
    op_done   = (byte_cnt_q == BW'(NB - 1));
    pay_last  = (rem_q == LEN_W'(1));
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    data_o  = acc_q[7:0];
    if (rst) begin
      case (state_q)
        StHdr, StOpnd: ready_o = 1'b1;
        StDrain:       ready_o = (rem_q != '0);
        StEcho: begin
          ready_o = ready_i;
          valid_o = valid_i;
          data_o  = data_i;
        end
        StTxRes:       valid_o = 1'b1;
        StTxErr: begin
          valid_o = 1'b1;
          data_o  = ERR_BYTE;
        end
        default: ;
      endcase
    end
    busy_o = rst && ((state_q != StHdr) || (hdr_cnt_q != 2'd0));
    err_o  = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StHdr;
      hdr_cnt_q  <= 2'd0;
      op_q       <= 8'd0;
      len_lo_q   <= 8'd0;
      rem_q      <= '0;
      byte_cnt_q <= '0;
      tx_cnt_q   <= '0;
      mul_cnt_q  <= '0;
      first_q    <= 1'b0;
      acc_q      <= '0;
      opnd_q     <= '0;
      mcand_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StHdr: begin
          if (in_fire) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd0) op_q <= data_i;
            if (hdr_cnt_q == 2'd2) len_lo_q <= data_i;
            if (hdr_cnt_q == 2'd3) begin
              rem_q      <= pay;
              byte_cnt_q <= '0;
              tx_cnt_q   <= '0;
              first_q    <= 1'b1;
              if (len_w < LEN_W'(4)) begin
                state_q <= StTxErr;
                err_q   <= 1'b1;
              end else if (op_q == OP_ECHO) begin
                state_q <= (pay == '0) ? StHdr : StEcho;
              end else if (is_arith && !pay_bad) begin
                state_q <= StOpnd;
              end else if (!is_arith && (pay == '0)) begin
                state_q <= StTxErr;
                err_q   <= 1'b1;
              end else begin
                state_q <= StDrain;
                err_q   <= 1'b1;
              end
            end
          end
        end
        StEcho: begin
          if (in_fire) begin
            rem_q <= rem_q - LEN_W'(1);
            if (pay_last) state_q <= StHdr;
          end
        end
        StOpnd: begin
          if (in_fire) begin
            rem_q      <= rem_q - LEN_W'(1);
            opnd_q     <= opnd_full;
            byte_cnt_q <= op_done ? '0 : byte_cnt_q + BW'(1);
            if (op_done) begin
              first_q <= 1'b0;
              if (first_q) begin
                acc_q <= opnd_full;
                if (pay_last) state_q <= StTxRes;
              end else if (op_q == OP_MUL) begin
                // Product is rebuilt into acc; the multiplier shifts out of opnd.
                mcand_q   <= acc_q;
                acc_q     <= '0;
                mul_cnt_q <= '0;
                state_q   <= StMulRun;
              end else begin
                acc_q <= (op_q == OP_SUB) ? acc_q - opnd_full : acc_q + opnd_full;
                if (pay_last) state_q <= StTxRes;
              end
            end
          end
        end
        StMulRun: begin
          if (opnd_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q   <= mcand_q << 1;
          opnd_q    <= opnd_q >> 1;
          mul_cnt_q <= mul_cnt_q + MW'(1);
          if (mul_cnt_q == MW'(OPW - 1)) state_q <= (rem_q == '0) ? StTxRes : StOpnd;
        end
        StDrain: begin
          if (rem_q == '0) begin
            state_q <= StTxErr;
          end else if (in_fire) begin
            rem_q <= rem_q - LEN_W'(1);
            if (pay_last) state_q <= StTxErr;
          end
        end
        StTxRes: begin
          if (out_fire) begin
            acc_q    <= acc_q >> 8;
            tx_cnt_q <= tx_cnt_q + BW'(1);
            if (tx_cnt_q == BW'(NB - 1)) state_q <= StHdr;
          end
        end
        StTxErr: begin
          if (out_fire) state_q <= StHdr;
        end
        default: state_q <= StHdr;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_core.sv
`timescale 1ns/1ps
// Bench for uart_alu_core: vector table, timing/backpressure/reset sequences and a
// random packet stream compared against a byte-level reference model.
module tb_uart_alu_core;
  localparam int unsigned OPW = 32;
  localparam int unsigned NB  = OPW / 8;
  localparam int NV = 15;

  logic       clk, rst, valid_i, ready_o, valid_o, ready_i, busy_o, err_o;
  logic [7:0] data_i, data_o;

  uart_alu_core #(.OPW(OPW), .LEN_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  typedef struct packed {
    logic [7:0]   n_in;
    logic [127:0] in_bits;   // bytes in send order, right-aligned
    logic [7:0]   n_out;
    logic [63:0]  out_bits;  // bytes in output order, right-aligned
    logic         err;
  } vec_t;

  vec_t       vecs [NV];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];
  int         err_cnt = 0;
  int         hold_bad = 0;
  bit         rnd_ready = 1'b0;
  logic       rdy_fixed = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  // Output collector; also watches that a stalled output stays put.
  initial begin
    bit         hold_pend = 1'b0;
    logic [7:0] hold_d = 8'd0;
    forever begin
      @(negedge clk);
      if (err_o) err_cnt++;
      if (rst && hold_pend && (!valid_o || data_o !== hold_d)) hold_bad++;
      hold_pend = rst && valid_o && !ready_i;
      hold_d    = data_o;
      if (rst && valid_o && ready_i) got_q.push_back(data_o);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit done = 1'b0;
    data_i  = b;
    valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ready_o) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 3000) begin
        check("send_byte_accepted", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic send_pkt(input int gapmax);
    foreach (pkt_q[i]) begin
      idle($urandom_range(0, gapmax));
      send_byte(pkt_q[i]);
    end
  endtask

  task automatic wait_out(input int target, input string name);
    int n = 0;
    while (got_q.size() < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_arrived"}, 64'(got_q.size() >= target), 64'd1);
  endtask

  task automatic set_pkt(input int n, input logic [127:0] bits);
    pkt_q.delete();
    for (int b = 0; b < n; b++) pkt_q.push_back(bits[8*(n-1-b) +: 8]);
  endtask

  // Reference: decode one packet from pkt_q, append the expected reply, return error count.
  function automatic int model_pkt();
    int unsigned       len, p;
    longint unsigned   acc, v, mask;
    logic [7:0]        op;
    op   = pkt_q[0];
    len  = {pkt_q[3], pkt_q[2]};
    mask = (OPW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << OPW) - 1);
    if (len < 4) begin
      exp_q.push_back(8'hEE);
      return 1;
    end
    p = len - 4;
    if (op == 8'hEC) begin
      for (int i = 0; i < int'(p); i++) exp_q.push_back(pkt_q[4+i]);
      return 0;
    end
    if (!(op inside {8'hA0, 8'hA1, 8'hA2}) || p == 0 || (p % NB) != 0) begin
      exp_q.push_back(8'hEE);
      return 1;
    end
    acc = 0;
    for (int k = 0; k < int'(p / NB); k++) begin
      v = 0;
      for (int b = 0; b < int'(NB); b++) v |= longint'(pkt_q[4 + k*NB + b]) << (8*b);
      if (k == 0) acc = v;
      else if (op == 8'hA0) acc = (acc + v) & mask;
      else if (op == 8'hA1) acc = (acc - v) & mask;
      else acc = (acc * v) & mask;
    end
    for (int j = 0; j < int'(NB); j++) exp_q.push_back(8'(acc >> (8*j)));
    return 0;
  endfunction

  initial begin
    int base, e0, n;
    logic [7:0] d0;

    vecs[0]  = '{8'd7,  128'hEC_00_07_00_61_62_63, 8'd3, 64'h61_62_63, 1'b0};
    vecs[1]  = '{8'd12, 128'hA0_00_0C_00_01_00_00_00_02_00_00_00, 8'd4, 64'h03_00_00_00, 1'b0};
    vecs[2]  = '{8'd12, 128'hA1_00_0C_00_03_00_00_00_05_00_00_00, 8'd4, 64'hFE_FF_FF_FF, 1'b0};
    vecs[3]  = '{8'd12, 128'hA2_00_0C_00_03_00_00_00_05_00_00_00, 8'd4, 64'h0F_00_00_00, 1'b0};
    vecs[4]  = '{8'd12, 128'hA2_00_0C_00_00_00_01_00_00_00_01_00, 8'd4, 64'h00_00_00_00, 1'b0};
    vecs[5]  = '{8'd6,  128'h55_00_06_00_11_22, 8'd1, 64'hEE, 1'b1};
    vecs[6]  = '{8'd7,  128'hA0_00_07_00_11_22_33, 8'd1, 64'hEE, 1'b1};
    vecs[7]  = '{8'd4,  128'hA0_00_02_00, 8'd1, 64'hEE, 1'b1};
    vecs[8]  = '{8'd4,  128'hEC_00_04_00, 8'd0, 64'h0, 1'b0};
    vecs[9]  = '{8'd8,  128'hA0_00_08_00_78_56_34_12, 8'd4, 64'h78_56_34_12, 1'b0};
    vecs[10] = '{8'd16, 128'hA2_00_10_00_02_00_00_00_03_00_00_00_07_00_00_00, 8'd4,
                 64'h2A_00_00_00, 1'b0};
    vecs[11] = '{8'd4,  128'hA0_00_04_00, 8'd1, 64'hEE, 1'b1};
    vecs[12] = '{8'd4,  128'h55_00_04_00, 8'd1, 64'hEE, 1'b1};
    vecs[13] = '{8'd12, 128'hA0_00_0C_00_FF_FF_FF_FF_02_00_00_00, 8'd4, 64'h01_00_00_00, 1'b0};
    vecs[14] = '{8'd16, 128'hA1_00_10_00_64_00_00_00_0A_00_00_00_14_00_00_00, 8'd4,
                 64'h46_00_00_00, 1'b0};

    // Reset
    rst = 1'b0; valid_i = 1'b0; data_i = 8'd0;
    idle(2);
    @(negedge clk);
    check("reset_valid_o", valid_o, 0);
    check("reset_ready_o", ready_o, 0);
    check("reset_busy_o", busy_o, 0);
    check("reset_err_o", err_o, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_ready_o", ready_o, 1);
    @(posedge clk); #1;

    // Echo is a same-cycle pass-through
    base = got_q.size();
    set_pkt(4, 128'hEC_00_07_00);
    send_pkt(0);
    for (int i = 0; i < 3; i++) begin
      data_i = 8'h61 + 8'(i);
      valid_i = 1'b1;
      @(negedge clk);
      check($sformatf("echo_valid%0d", i), valid_o, 1);
      check($sformatf("echo_data%0d", i), data_o, 8'h61 + 8'(i));
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    @(negedge clk);
    check("echo_busy_after", busy_o, 0);
    check("echo_count", got_q.size() - base, 3);
    @(posedge clk); #1;

    // Add result one cycle after the last byte; multiply OPW cycles later
    for (int t = 0; t < 2; t++) begin
      base = got_q.size();
      set_pkt(12, (t == 0) ? 128'hA0_00_0C_00_01_00_00_00_02_00_00_00
                           : 128'hA2_00_0C_00_03_00_00_00_05_00_00_00);
      send_pkt(0);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!valid_o && n < 200);
      check(t == 0 ? "add_latency" : "mul_latency", n, t == 0 ? 1 : OPW + 1);
      wait_out(base + 4, "lat");
      check(t == 0 ? "add_lsb" : "mul_lsb", got_q[base], t == 0 ? 8'h03 : 8'h0F);
      idle(5);
    end

    // Backpressure on the result
    rdy_fixed = 1'b0;
    idle(1);
    base = got_q.size();
    set_pkt(12, 128'hA0_00_0C_00_01_00_00_00_02_00_00_00);
    send_pkt(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < 200);
    check("bp_valid_seen", valid_o, 1);
    d0 = data_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), valid_o, 1);
      check($sformatf("bp_hold_data%0d", i), data_o, d0);
      check($sformatf("bp_ready_o%0d", i), ready_o, 0);
    end
    rdy_fixed = 1'b1;
    wait_out(base + 4, "bp");
    for (int j = 0; j < 4; j++)
      check($sformatf("bp_byte%0d", j), got_q[base+j], (j == 0) ? 8'h03 : 8'h00);
    idle(5);

    // Vector table under random output stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      logic [127:0] ib;
      logic [63:0]  ob;
      int           no;
      ib = vecs[i].in_bits;
      ob = vecs[i].out_bits;
      no = int'(vecs[i].n_out);
      base = got_q.size();
      e0 = err_cnt;
      set_pkt(int'(vecs[i].n_in), ib);
      send_pkt(1);
      wait_out(base + no, $sformatf("vec%0d", i));
      idle(45);
      check($sformatf("vec%0d_count", i), got_q.size() - base, no);
      for (int j = 0; j < no; j++)
        check($sformatf("vec%0d_byte%0d", i, j), got_q[base+j], ob[8*(no-1-j) +: 8]);
      check($sformatf("vec%0d_err_pulses", i), err_cnt - e0, vecs[i].err);
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), busy_o, 0);
      @(posedge clk); #1;
    end

    // Reset mid-operand discards the packet
    rnd_ready = 1'b0;
    rdy_fixed = 1'b1;
    idle(1);
    base = got_q.size();
    set_pkt(6, 128'hA0_00_0C_00_01_00);
    send_pkt(0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid_o", valid_o, 0);
    check("midrst_ready_o", ready_o, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy_after", busy_o, 0);
    @(posedge clk); #1;
    set_pkt(12, 128'hA0_00_0C_00_05_00_00_00_06_00_00_00);
    send_pkt(0);
    wait_out(base + 4, "midrst");
    idle(45);
    check("midrst_count", got_q.size() - base, 4);
    check("midrst_byte0", got_q[base], 8'h0B);
    check("midrst_byte1", got_q[base+1], 8'h00);

    // Random back-to-back packet stream
    rnd_ready = 1'b1;
    base = got_q.size();
    e0 = err_cnt;
    exp_q.delete();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      int unsigned kind, p, len;
      logic [7:0]  op;
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin op = 8'hEC; p = $urandom_range(0, 8); len = p + 4; end
        1, 2, 3: begin op = 8'hA0 + 8'(kind - 1); p = NB * $urandom_range(1, 3); len = p + 4; end
        4: begin
          op = 8'hA0 + 8'($urandom_range(0, 2));
          p = NB * $urandom_range(0, 1) + $urandom_range(1, NB - 1);
          len = p + 4;
        end
        default: begin
          if ($urandom_range(0, 1) != 0) begin
            op = ($urandom_range(0, 1) != 0) ? 8'h55 : 8'h3C;
            p = $urandom_range(0, 3);
            len = p + 4;
          end else begin
            op = 8'hA0; p = 0; len = $urandom_range(0, 3);
          end
        end
      endcase
      pkt_q.delete();
      pkt_q.push_back(op);
      pkt_q.push_back(8'($urandom));
      pkt_q.push_back(8'(len));
      pkt_q.push_back(8'(len >> 8));
      for (int i = 0; i < int'(p); i++) pkt_q.push_back(8'($urandom));
      n += model_pkt();
      send_pkt(2);
    end
    wait_out(base + exp_q.size(), "rand");
    idle(60);
    check("rand_count", got_q.size() - base, exp_q.size());
    foreach (exp_q[j])
      if (base + j < got_q.size())
        check($sformatf("rand_byte%0d", j), got_q[base+j], exp_q[j]);
    check("rand_err_pulses", err_cnt - e0, n);
    check("hold_violations", hold_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
